// File: rtl/uart_tx_frame.sv
// 8-bit UART transmitter: start, 8 data bits LSB first, optional parity, stop bits.
// The serial line is registered and always reflects the state being entered.
module uart_tx_frame #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] data_in,
    input  logic [1:0] parity_type,
    output logic       data_tx,
    output logic       ready,
    output logic       active_flag,
    output logic       done_flag
);

    localparam int unsigned CLOG = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam int unsigned CW   = (CLOG < 1) ? 1 : CLOG;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT * STOP_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    par_q, par_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          par_en;

    assign par_en = par_q[0] ^ par_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        data_d  = data_q;
        par_d   = par_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (send) begin
                    data_d  = data_in;
                    par_d   = parity_type;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == STOP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Line value is derived from the next state so it lines up with state_q.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_d];
            PARITY:  tx_d = par_d[0] ? ~^data_d : ^data_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            par_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign data_tx     = tx_q;
    assign done_flag   = done_q;
    assign ready       = (state_q == IDLE);
    assign active_flag = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at 4 clocks/bit, one and two stop bits.
// Expected frames are hand-serialised; bit k of exp is the k-th bit on the line.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       send1 = 1'b0;
    logic       send2 = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [1:0] parity_type = 2'b00;

    logic tx1, rdy1, act1, dn1;
    logic tx2, rdy2, act2, dn2;

    int checks = 0;
    int errors = 0;
    bit cur = 1'b0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
        .clock(clk), .reset(reset), .send(send1),
        .data_in(data_in), .parity_type(parity_type),
        .data_tx(tx1), .ready(rdy1),
        .active_flag(act1), .done_flag(dn1)
    );

    uart_tx_frame #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
        .clock(clk), .reset(reset), .send(send2),
        .data_in(data_in), .parity_type(parity_type),
        .data_tx(tx2), .ready(rdy2),
        .active_flag(act2), .done_flag(dn2)
    );

    logic tx, rdy, act, dn;
    assign tx  = cur ? tx2  : tx1;
    assign rdy = cur ? rdy2 : rdy1;
    assign act = cur ? act2 : act1;
    assign dn  = cur ? dn2  : dn1;

    typedef struct {
        logic [7:0]  d;
        logic [1:0]  p;
        bit          sel;
        logic [11:0] exp;
        int          nb;
        bit          scr;
        string       nm;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic set_send(input bit sel, input logic v);
        if (sel) send2 = v;
        else send1 = v;
    endtask

    // Called at a negedge with send already raised for the selected DUT.
    task automatic frame(input logic [7:0] d, input logic [1:0] p,
                         input logic [11:0] exp, input int nb,
                         input bit sel, input bit scr, input bit hold,
                         input string nm);
        int L;
        int bad_line;
        int bad_flag;
        logic [11:0] got;
        L = nb * 4;
        bad_line = 0;
        bad_flag = 0;
        got = '0;
        cur = sel;
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            if (k == 0 && !hold) set_send(sel, 1'b0);
            if (scr && k == 6) begin
                data_in = ~d;
                parity_type = ~p;
                set_send(sel, 1'b1);
            end
            if (scr && k == L - 2) set_send(sel, 1'b0);
            if (tx !== exp[k/4]) bad_line++;
            if (k % 4 == 2) got[k/4] = tx;
            if (rdy !== 1'b0 || act !== 1'b1 || dn !== 1'b0) bad_flag++;
        end
        chk({nm, "_line"}, 32'(got), 32'(exp));
        chk({nm, "_line_stable"}, bad_line, 0);
        chk({nm, "_busy_flags"}, bad_flag, 0);
        @(negedge clk);
        chk({nm, "_done_cycle"}, {28'd0, dn, rdy, act, tx}, 32'hD);
    endtask

    task automatic idle_chk(input string nm);
        chk({nm, "_idle1"}, {28'd0, dn1, rdy1, act1, tx1}, 32'h5);
        chk({nm, "_idle2"}, {28'd0, dn2, rdy2, act2, tx2}, 32'h5);
    endtask

    initial begin
        int nodone;

        tbl[0] = '{8'hA5, 2'b00, 1'b0, 12'b110100101_0, 10, 1'b0, "A5_none"};
        tbl[1] = '{8'h01, 2'b01, 1'b0, 12'b10000000010, 11, 1'b0, "01_odd"};
        tbl[2] = '{8'h01, 2'b10, 1'b0, 12'b11000000010, 11, 1'b0, "01_even"};
        tbl[3] = '{8'h00, 2'b01, 1'b0, 12'b11000000000, 11, 1'b1, "00_odd_scr"};
        tbl[4] = '{8'hC3, 2'b10, 1'b0, 12'b10110000110, 11, 1'b1, "C3_even_scr"};
        tbl[5] = '{8'hFF, 2'b10, 1'b1, 12'b110111111110, 12, 1'b0, "FF_even_stop2"};

        // Reset state, with send asserted to show reset wins.
        @(negedge clk);
        idle_chk("reset");
        send1 = 1'b1;
        data_in = 8'h55;
        @(negedge clk);
        idle_chk("reset_over_send");
        send1 = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        idle_chk("post_reset");

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idle_chk({tbl[i].nm, "_pre"});
            data_in = tbl[i].d;
            parity_type = tbl[i].p;
            set_send(tbl[i].sel, 1'b1);
            frame(tbl[i].d, tbl[i].p, tbl[i].exp, tbl[i].nb,
                  tbl[i].sel, tbl[i].scr, 1'b0, tbl[i].nm);
        end

        // Back-to-back frames with send held high throughout the first.
        @(negedge clk);
        data_in = 8'h3C;
        parity_type = 2'b11;
        send1 = 1'b1;
        frame(8'h3C, 2'b11, 12'b1001111000, 10, 1'b0, 1'b0, 1'b1, "b2b_3C");
        data_in = 8'hC3;
        parity_type = 2'b10;
        frame(8'hC3, 2'b10, 12'b10110000110, 11, 1'b0, 1'b0, 1'b0, "b2b_C3");

        // Abort during data bit 4 of an all-zero frame.
        @(negedge clk);
        data_in = 8'h00;
        parity_type = 2'b00;
        send1 = 1'b1;
        @(negedge clk);
        send1 = 1'b0;
        for (int k = 1; k <= 21; k++) @(negedge clk);
        chk("abort_bit4_low", {31'd0, tx1}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_state", {28'd0, dn1, rdy1, act1, tx1}, 32'h5);
        nodone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (dn1 !== 1'b0 || tx1 !== 1'b1) nodone++;
        end
        chk("abort_no_done", nodone, 0);

        data_in = 8'h5A;
        send1 = 1'b1;
        frame(8'h5A, 2'b00, 12'b1010110100, 10, 1'b0, 1'b0, 1'b0, "after_abort_5A");
        @(negedge clk);
        idle_chk("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
